// File: rtl/shift_rows_pipe_if.sv
// rtl/shift_rows_pipe_if.sv - valid/ready beat carrying a Rijndael state and its direction bit
interface shift_rows_pipe_if #(
  parameter int W = 128
);
  logic         valid;
  logic         ready;
  logic         inv;
  logic [W-1:0] data;

  modport master (output valid, output inv, output data, input ready);
  modport slave  (input valid, input inv, input data, output ready);
endinterface

// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - registered ShiftRows/InvShiftRows with a 2-entry skid buffer
module shift_rows_pipe #(
  parameter int NB = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  shift_rows_pipe_if.slave   i_s,
  shift_rows_pipe_if.master  o_m
);
  localparam int W = 32 * NB;

  generate
    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
  endgenerate

  // Byte k sits at row k%4, column k/4, most significant byte first.
  function automatic logic [W-1:0] f_perm(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] res;
    int           s;
    int           src;
    res = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        s   = (NB == 8 && r >= 2) ? r + 1 : r;
        src = inv ? (c - s + NB) % NB : (c + s) % NB;
        res[W-1-8*(4*c+r) -: 8] = d[W-1-8*(4*src+r) -: 8];
      end
    end
    return res;
  endfunction

  logic         r_o_valid;
  logic         r_o_inv;
  logic [W-1:0] r_o_data;
  logic         r_s_valid;
  logic         r_s_inv;
  logic [W-1:0] r_s_data;

  logic [W-1:0] w_perm;
  logic         w_acc;
  logic         w_pop;
  logic         w_o_free;

  assign w_perm   = f_perm(i_s.data, i_s.inv);
  assign w_acc    = i_s.valid & ~r_s_valid;
  assign w_pop    = r_o_valid & o_m.ready;
  assign w_o_free = ~r_o_valid | w_pop;

  assign i_s.ready = ~r_s_valid;
  assign o_m.valid = r_o_valid;
  assign o_m.inv   = r_o_inv;
  assign o_m.data  = r_o_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o_valid <= 1'b0;
      r_o_inv   <= 1'b0;
      r_o_data  <= '0;
      r_s_valid <= 1'b0;
      r_s_inv   <= 1'b0;
      r_s_data  <= '0;
    end else if (flush) begin
      r_o_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else if (w_o_free) begin
      if (r_s_valid) begin
        // Skid beat is older than anything arriving now, so it moves up first.
        r_o_valid <= 1'b1;
        r_o_inv   <= r_s_inv;
        r_o_data  <= r_s_data;
        r_s_valid <= w_acc;
        if (w_acc) begin
          r_s_inv  <= i_s.inv;
          r_s_data <= w_perm;
        end
      end else begin
        r_o_valid <= w_acc;
        if (w_acc) begin
          r_o_inv  <= i_s.inv;
          r_o_data <= w_perm;
        end
      end
    end else if (w_acc) begin
      r_s_valid <= 1'b1;
      r_s_inv   <= i_s.inv;
      r_s_data  <= w_perm;
    end
  end
endmodule
